// File: rtl/shift_reg_pkg.sv
// Shared definitions for the universal shift register: mode encodings and
// the parameter legality check used at elaboration time.
package shift_reg_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_UP   = 2'b01;
  localparam logic [1:0] MODE_DOWN = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  // CNT must be able to hold the value WIDTH itself, since it saturates there.
  function automatic bit cw_fits(input int width, input int cw);
    return (64'd1 << cw) > 64'(width);
  endfunction

endpackage

// File: rtl/shift_reg_cell.sv
// One stage of the universal shift register: 4:1 next-state select
// (own bit, lower neighbour, upper neighbour, parallel bit) feeding a flop.
module shift_reg_cell
  import shift_reg_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] mode,
  input  logic       lo_bit,
  input  logic       hi_bit,
  input  logic       par_bit,
  output logic       q
);

  logic d;

  always_comb begin
    // NOTE: default assigned first so no path leaves d unassigned (no latch).
    d = q;
    case (mode)
      MODE_HOLD: d = q;
      MODE_UP:   d = lo_bit;
      MODE_DOWN: d = hi_bit;
      default:   d = par_bit;
    endcase
  end

  // NOTE: non-blocking for flop state so every stage samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) q <= 1'b0;
    else     q <= d;
  end

endmodule

// File: rtl/shift_reg_univ.sv
// Parametrised universal shift register with saturating accepted-bit count.
// Optional rotate input ROT is enabled by defining SHIFT_REG_ROTATE_EN.
module shift_reg_univ
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CW    = 4
) (
  input  logic             C,
  input  logic             R,
  input  logic [1:0]       M,
`ifdef SHIFT_REG_ROTATE_EN
  input  logic             ROT,
`endif
  input  logic             SIL,
  input  logic             SIH,
  input  logic [WIDTH-1:0] P,
  output logic [WIDTH-1:0] Q,
  output logic             SOH,
  output logic             SOL,
  output logic [CW-1:0]    CNT,
  output logic             FULL
);

  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

  if (WIDTH < 2 || WIDTH > 32) begin : g_width_check
    $error("shift_reg_univ: WIDTH must be in 2..32");
  end
  if (!cw_fits(WIDTH, CW)) begin : g_cw_check
    $error("shift_reg_univ: CW too narrow, need 2**CW > WIDTH");
  end

  logic rot;
`ifdef SHIFT_REG_ROTATE_EN
  assign rot = ROT;
`else
  assign rot = 1'b0;
`endif

  // End stages take the serial inputs, or the opposite end bit when rotating.
  logic lo_edge;
  logic hi_edge;
  assign lo_edge = rot ? Q[WIDTH-1] : SIL;
  assign hi_edge = rot ? Q[0]       : SIH;

  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    logic lo_bit;
    logic hi_bit;
    if (i == 0) begin : g_lo_edge
      assign lo_bit = lo_edge;
    end else begin : g_lo_inner
      assign lo_bit = Q[i-1];
    end
    if (i == WIDTH - 1) begin : g_hi_edge
      assign hi_bit = hi_edge;
    end else begin : g_hi_inner
      assign hi_bit = Q[i+1];
    end

    shift_reg_cell u_cell (
      .clk    (C),
      .rst    (R),
      .mode   (M),
      .lo_bit (lo_bit),
      .hi_bit (hi_bit),
      .par_bit(P[i]),
      .q      (Q[i])
    );
  end

  // A rotate moves existing bits only, so it is not an accepted serial bit.
  logic accept;
  assign accept = (M == MODE_UP || M == MODE_DOWN) && !rot;

  logic [CW-1:0] cnt_q;

  always_ff @(posedge C) begin
    if (R)                                cnt_q <= '0;
    else if (M == MODE_LOAD)              cnt_q <= '0;
    else if (accept && cnt_q != CNT_MAX)  cnt_q <= cnt_q + 1'b1;
  end

  assign CNT  = cnt_q;
  assign FULL = (cnt_q == CNT_MAX);
  assign SOH  = Q[WIDTH-1];
  assign SOL  = Q[0];

endmodule

// File: tb/tb_shift_reg_univ.sv
// Scoreboard bench for shift_reg_univ at WIDTH=4, CW=3: the driver pushes
// hand-computed expectations, a negedge monitor pops and compares them.
module tb_shift_reg_univ;

  localparam int WIDTH = 4;
  localparam int CW    = 3;

  logic             clk = 1'b0;
  logic             r   = 1'b0;
  logic [1:0]       m   = 2'b00;
  logic             rot = 1'b0;
  logic             sil = 1'b0;
  logic             sih = 1'b0;
  logic [WIDTH-1:0] p   = '0;
  logic [WIDTH-1:0] q;
  logic             soh;
  logic             sol;
  logic [CW-1:0]    cnt;
  logic             full;

  always #5 clk = ~clk;

  shift_reg_univ #(.WIDTH(WIDTH), .CW(CW)) dut (
    .C   (clk),
    .R   (r),
    .M   (m),
`ifdef SHIFT_REG_ROTATE_EN
    .ROT (rot),
`endif
    .SIL (sil),
    .SIH (sih),
    .P   (p),
    .Q   (q),
    .SOH (soh),
    .SOL (sol),
    .CNT (cnt),
    .FULL(full)
  );

  typedef struct {
    int               id;
    logic [WIDTH-1:0] q;
    logic [CW-1:0]    cnt;
    logic             full;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input int id,
                       input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, id, act, req);
    end
  endtask

  // Monitor: outputs are stable at the falling edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("q",    e.id, 32'(q),    32'(e.q));
      check("cnt",  e.id, 32'(cnt),  32'(e.cnt));
      check("full", e.id, 32'(full), 32'(e.full));
      check("sol",  e.id, 32'(sol),  32'(e.q[0]));
      check("soh",  e.id, 32'(soh),  32'(e.q[WIDTH-1]));
    end
  end

  int step_id = 0;

  // Drive one edge's inputs (called just after a falling edge), then queue
  // the hand-computed post-edge state.
  task automatic step(input logic r_i, input logic [1:0] m_i, input logic rot_i,
                      input logic sil_i, input logic sih_i, input logic [WIDTH-1:0] p_i,
                      input logic [WIDTH-1:0] eq, input logic [CW-1:0] ecnt,
                      input logic efull);
    exp_t e;
    r = r_i; m = m_i; rot = rot_i; sil = sil_i; sih = sih_i; p = p_i;
    @(posedge clk);
    #1;
    e.id = step_id; e.q = eq; e.cnt = ecnt; e.full = efull;
    exp_q.push_back(e);
    step_id++;
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    // Preload, then reset overriding a load of all ones.
    step(0, 2'b11, 0, 0, 0, 4'b1011, 4'b1011, 3'd0, 0);
    step(1, 2'b11, 0, 0, 0, 4'b1111, 4'b0000, 3'd0, 0);
    // Shift-up with SIH held high (must be ignored).
    step(0, 2'b01, 0, 1, 1, 4'b1111, 4'b0001, 3'd1, 0);
    step(0, 2'b01, 0, 0, 1, 4'b1111, 4'b0010, 3'd2, 0);
    step(0, 2'b01, 0, 1, 1, 4'b1111, 4'b0101, 3'd3, 0);
    step(0, 2'b01, 0, 1, 1, 4'b1111, 4'b1011, 3'd4, 1);
    // Saturation.
    step(0, 2'b01, 0, 0, 0, 4'b0000, 4'b0110, 3'd4, 1);
    step(0, 2'b01, 0, 0, 0, 4'b0000, 4'b1100, 3'd4, 1);
    // Load, shift-down with SIL high (ignored), then hold.
    step(0, 2'b11, 0, 0, 0, 4'b1001, 4'b1001, 3'd0, 0);
    step(0, 2'b10, 0, 1, 0, 4'b0000, 4'b0100, 3'd1, 0);
    step(0, 2'b00, 0, 1, 1, 4'b1111, 4'b0100, 3'd1, 0);
    step(0, 2'b00, 0, 0, 1, 4'b1111, 4'b0100, 3'd1, 0);
    step(0, 2'b00, 0, 1, 0, 4'b0000, 4'b0100, 3'd1, 0);
    // Mixed directions each count.
    step(0, 2'b01, 0, 1, 0, 4'b0000, 4'b1001, 3'd2, 0);
    step(0, 2'b10, 0, 0, 1, 4'b0000, 4'b1100, 3'd3, 0);
    step(0, 2'b01, 0, 0, 1, 4'b0000, 4'b1000, 3'd4, 1);
    step(0, 2'b10, 0, 1, 0, 4'b0000, 4'b0100, 3'd4, 1);
    // Reset mid shift-up run: the shift is not applied.
    step(1, 2'b00, 0, 0, 0, 4'b0000, 4'b0000, 3'd0, 0);
    step(0, 2'b01, 0, 1, 0, 4'b0000, 4'b0001, 3'd1, 0);
    step(1, 2'b01, 0, 1, 0, 4'b0000, 4'b0000, 3'd0, 0);
    // Shift-down fill from zero to saturation.
    step(0, 2'b10, 0, 0, 1, 4'b0000, 4'b1000, 3'd1, 0);
    step(0, 2'b10, 0, 0, 1, 4'b0000, 4'b1100, 3'd2, 0);
    step(0, 2'b10, 0, 0, 1, 4'b0000, 4'b1110, 3'd3, 0);
    step(0, 2'b10, 0, 0, 1, 4'b0000, 4'b1111, 3'd4, 1);
    step(0, 2'b10, 0, 0, 0, 4'b0000, 4'b0111, 3'd4, 1);
`ifdef SHIFT_REG_ROTATE_EN
    // Rotate: serial inputs ignored, count untouched; ROT inert for hold/load.
    step(0, 2'b11, 0, 0, 0, 4'b1000, 4'b1000, 3'd0, 0);
    step(0, 2'b01, 1, 0, 1, 4'b0000, 4'b0001, 3'd0, 0);
    step(0, 2'b01, 1, 0, 1, 4'b0000, 4'b0010, 3'd0, 0);
    step(0, 2'b10, 1, 1, 0, 4'b0000, 4'b0001, 3'd0, 0);
    step(0, 2'b10, 1, 1, 1, 4'b0000, 4'b1000, 3'd0, 0);
    step(0, 2'b11, 1, 1, 1, 4'b0110, 4'b0110, 3'd0, 0);
    step(0, 2'b00, 1, 1, 1, 4'b1111, 4'b0110, 3'd0, 0);
`endif
    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d entries left expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_reg_univ.md
Name: shift_reg_univ

Overview:
- Parametrised universal shift register; successor to the fixed 2-bit serial shift chain.
- Supports:
  - configurable width;
  - hold, shift-up, shift-down and parallel-load modes;
  - synchronous reset;
  - a saturating count of serial bits accepted.
- Sits between serial stimulus sources and parallel consumers in the simulator test designs.
- Also serves as the hierarchical benchmark for multi-instance flop chains.

Parameters:
- WIDTH, 8, number of register stages; legal range 2..32.
- CW, 4, width of CNT; must satisfy 2**CW > WIDTH (default pair 8/4).

Ports:
- C  input  1  clock; all state updates on the rising edge.
- R  input  1  synchronous active-high reset.
- M  input  2  mode: 00 hold, 01 shift-up, 10 shift-down, 11 parallel load.
- SIL  input  1  serial input entering Q[0] on shift-up.
- SIH  input  1  serial input entering Q[WIDTH-1] on shift-down.
- P  input  WIDTH  parallel load data.
- Q  output  WIDTH  register contents.
- SOH  output  1  equals Q[WIDTH-1].
- SOL  output  1  equals Q[0].
- CNT  output  CW  serial bits accepted since last reset/load; saturates at WIDTH.
- FULL  output  1  high when CNT == WIDTH.

Behaviour:
- Reset: one clock, synchronous and active-high. On a rising C edge with R=1, regardless of M:
  - Q <= 0, CNT <= 0.
  - SOH, SOL and FULL therefore read 0 after that edge.
- R has priority over every mode. Asserting R mid-sequence discards the contents at the next edge; no partial update.
- Update rules with R=0, per rising edge:
  - M=00: Q and CNT unchanged.
  - M=01: Q <= {Q[WIDTH-2:0], SIL}; old Q[WIDTH-1] is lost. CNT <= min(CNT+1, WIDTH).
  - M=10: Q <= {SIH, Q[WIDTH-1:1]}; old Q[0] is lost. CNT <= min(CNT+1, WIDTH).
  - M=11: Q <= P; CNT <= 0.
- Latency: Q, CNT and FULL reflect an edge immediately after it, i.e. one-cycle register latency.
- SOH, SOL and FULL are combinational decodes of registered state only; no input-to-output combinational path.
- CNT saturation:
  - at CNT == WIDTH further shifts keep CNT at WIDTH;
  - no wrap-around to 0;
  - FULL stays 1 until reset or load.
- Mixed directions: alternating up/down shifts each increment CNT. CNT counts accepted bits, not net position.
- SIL is ignored in every mode except 01; SIH is ignored in every mode except 10.
- No X propagation from unused serial inputs.
- Inputs are sampled only at the edge. Changes of M, SIL, SIH or P between edges have no effect. This is relevant for the event-driven simulator, where inputs and C may change in the same timestep: the value before the edge is the sampled value.

Optional Feature:
- Macro: SHIFT_REG_ROTATE_EN.
- Defined:
  - adds input ROT (1 bit).
  - When ROT=1 and M=01: Q <= {Q[WIDTH-2:0], Q[WIDTH-1]}.
  - When ROT=1 and M=10: Q <= {Q[0], Q[WIDTH-1:1]}.
  - Serial inputs are ignored and CNT is unchanged during a rotate, because no new bits are accepted.
  - ROT has no effect for M=00 or M=11.
- Undefined: ROT port absent; behaviour identical to ROT=0.

Decomposition:
- Shared package `shift_reg_pkg` holds:
  - mode constants MODE_HOLD=2'b00, MODE_UP=2'b01, MODE_DOWN=2'b10, MODE_LOAD=2'b11;
  - the constraint check that 2**CW > WIDTH.
- One sub-module, `shift_reg_cell`:
  - a single stage with a 4:1 next-state select (own bit, lower neighbour, upper neighbour, parallel bit), reset and flop;
  - instantiated WIDTH times by generate, with boundary neighbours wired to SIL/SIH (or the wrap bits under SHIFT_REG_ROTATE_EN).
- Counter and FULL logic live in the top module.

Test Plan (WIDTH=4, CW=3):
- Reset: preload Q=4'b1011, assert R=1 with M=11 and P=4'b1111 for one edge -> Q=0000, CNT=0, FULL=0.
- Shift-up: from reset, M=01, SIL=1,0,1,1 on four edges -> Q=0001, 0010, 0101, 1011; CNT=1,2,3,4; FULL=1 after the fourth edge.
- Saturation: two more M=01 edges with SIL=0 -> Q=0110 then 1100; CNT remains 4; FULL remains 1.
- Load and shift-down: M=11 with P=4'b1001 -> Q=1001, CNT=0. Then M=10 with SIH=0 -> Q=0100, SOL=0, CNT=1. Then M=00 for 3 edges -> unchanged.
- Reset mid-operation: during a shift-up run, R=1 on the same edge as M=01, SIL=1 -> Q=0000, CNT=0; the shift is not applied.
- Rotate (with SHIFT_REG_ROTATE_EN): load 4'b1000, then M=01, ROT=1, SIL=0 for 2 edges -> Q=0001 then 0010; CNT stays 0.
